// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB slave with a word-addressed SRAM, pipelined address/data phases and a two-cycle ERROR.
// Define AHB_SLV_WAIT_EN to build the WAIT state and its counter (WAIT_CYCLES wait states per OKAY transfer).
module ahb_slave_mem #(
  parameter int          MEM_DEPTH   = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSELx,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        ready_in,
  output logic        HREADY,
  output logic        HRESP,
  output logic [31:0] HRDATA
);
  localparam int          AW     = $clog2(MEM_DEPTH);
  localparam logic [32:0] WINDOW = 33'(MEM_DEPTH) << 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_ERR1 = 3'd2,
    S_ERR2 = 3'd3
`ifdef AHB_SLV_WAIT_EN
    , S_WAIT = 3'd4
`endif
  } state_t;

  state_t        state_reg;
  logic          hready_reg;
  logic          hresp_reg;
  logic          write_reg;
  logic [AW-1:0] idx_reg;
  logic [3:0]    strb_reg;

  logic [31:0]   mem [MEM_DEPTH];
  logic [31:0]   rd_word_reg;
  logic [31:0]   fwd_data_reg;
  logic [3:0]    fwd_strb_reg;
  logic          rd_valid_reg;

  logic [31:0]   offset;
  logic          in_window;
  logic          err_next;
  logic [3:0]    strb_next;
  logic [AW-1:0] idx_next;
  logic [AW-1:0] rd_idx;
  logic          accept;
  logic          commit;
  logic          enter_rd;
  logic          unused_burst;

  assign unused_burst = ^HBURST;

  // Offset wraps below BASE_ADDR, so one unsigned compare covers both ends of the window.
  assign offset    = HADDR - BASE_ADDR;
  assign in_window = {1'b0, offset} < WINDOW;
  assign idx_next  = offset[AW+1:2];

  always_comb begin
    err_next = !in_window || (HSIZE > 3'd2) ||
               (HSIZE == 3'd1 && HADDR[0]) ||
               (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
    strb_next = 4'b0000;
    case (HSIZE)
      3'd0:    strb_next = 4'b0001 << HADDR[1:0];
      3'd1:    strb_next = HADDR[1] ? 4'b1100 : 4'b0011;
      default: strb_next = 4'b1111;
    endcase
  end

  // HREADY low (WAIT, ERR1) blocks address sampling regardless of ready_in.
  assign accept = HSELx && ready_in && HTRANS[1] && hready_reg;
  assign commit = (state_reg == S_DATA) && write_reg;

`ifdef AHB_SLV_WAIT_EN
  localparam bit WAIT_ON = (WAIT_CYCLES > 0);
  logic [15:0] cnt_reg;
  logic        wait_done;

  assign wait_done = (state_reg == S_WAIT) && (cnt_reg <= 16'd1);
  assign enter_rd  = (accept && !err_next && !WAIT_ON && !HWRITE) || (wait_done && !write_reg);
  assign rd_idx    = wait_done ? idx_reg : idx_next;
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;
  assign enter_rd = accept && !err_next && !HWRITE;
  assign rd_idx   = idx_next;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      hready_reg <= 1'b1;
      hresp_reg  <= 1'b0;
      write_reg  <= 1'b0;
      idx_reg    <= '0;
      strb_reg   <= '0;
`ifdef AHB_SLV_WAIT_EN
      cnt_reg    <= '0;
`endif
    end else begin
      case (state_reg)
`ifdef AHB_SLV_WAIT_EN
        S_WAIT: begin
          if (wait_done) begin
            state_reg  <= S_DATA;
            hready_reg <= 1'b1;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
`endif
        S_ERR1: begin
          state_reg  <= S_ERR2;
          hready_reg <= 1'b1;
          hresp_reg  <= 1'b1;
        end
        default: begin
          if (accept) begin
            write_reg <= HWRITE;
            idx_reg   <= idx_next;
            strb_reg  <= strb_next;
            if (err_next) begin
              state_reg  <= S_ERR1;
              hready_reg <= 1'b0;
              hresp_reg  <= 1'b1;
            end
`ifdef AHB_SLV_WAIT_EN
            else if (WAIT_ON) begin
              state_reg  <= S_WAIT;
              hready_reg <= 1'b0;
              hresp_reg  <= 1'b0;
              cnt_reg    <= 16'(WAIT_CYCLES);
            end
`endif
            else begin
              state_reg  <= S_DATA;
              hready_reg <= 1'b1;
              hresp_reg  <= 1'b0;
            end
          end else begin
            state_reg  <= S_IDLE;
            hready_reg <= 1'b1;
            hresp_reg  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Byte-lane write at the end of the DATA cycle; a reset on that edge abandons it.
  always_ff @(posedge clk) begin
    if (reset && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_reg[b]) mem[idx_reg][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    rd_word_reg  <= mem[rd_idx];
    fwd_data_reg <= HWDATA;
  end

  // A read sampled on the same edge as a write to its word takes the written lanes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_valid_reg <= 1'b0;
      fwd_strb_reg <= 4'b0000;
    end else begin
      rd_valid_reg <= enter_rd;
      fwd_strb_reg <= (commit && rd_idx == idx_reg) ? strb_reg : 4'b0000;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign HRDATA[8*gi +: 8] = !rd_valid_reg     ? 8'h00 :
                               fwd_strb_reg[gi]  ? fwd_data_reg[8*gi +: 8] :
                                                   rd_word_reg[8*gi +: 8];
  end

  assign HREADY = hready_reg;
  assign HRESP  = hresp_reg;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: directed and randomized transfers against a byte-lane memory model of ahb_slave_mem.
module tb_ahb_slave_mem;
  localparam int MEM_DEPTH = 256;
`ifdef AHB_SLV_WAIT_EN
  localparam int EXP_WAITS = 2;
`else
  localparam int EXP_WAITS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        HSELx = 1'b0;
  logic [31:0] HADDR = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = '0;
  logic [1:0]  HTRANS = '0;
  logic [2:0]  HBURST = '0;
  logic [31:0] HWDATA = '0;
  logic        ready_in = 1'b1;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [MEM_DEPTH];

  always #5 clk = ~clk;

  ahb_slave_mem #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .HSELx(HSELx), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HBURST(HBURST), .HWDATA(HWDATA),
    .ready_in(ready_in), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bytes addr[1:0] .. addr[1:0]+2**size-1 of the addressed word take the matching bytes of wdata.
  function automatic void model_write(input logic [31:0] addr, input logic [2:0] size,
                                      input logic [31:0] wdata);
    int first  = int'(addr[1:0]);
    int nbytes = 1 << size;
    int w      = int'(addr >> 2);
    for (int b = first; b < first + nbytes; b++) model[w][8*b +: 8] = wdata[8*b +: 8];
  endfunction

  task automatic wait_ready(output int waits);
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (HREADY === 1'b1) break;
      waits++;
    end
  endtask

  task automatic okay_xfer(input string tag, input bit wr, input logic [31:0] addr,
                           input logic [2:0] size, input logic [31:0] wdata,
                           output logic [31:0] rdata);
    int waits;
    HSELx = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size; ready_in = 1'b1;
    @(posedge clk); #1;
    HSELx = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    wait_ready(waits);
    rdata = HRDATA;
    check({tag, "/ready"}, 32'(HREADY), 32'd1);
    check({tag, "/waits"}, 32'(waits), 32'(EXP_WAITS));
    check({tag, "/resp"}, 32'(HRESP), 32'd0);
    if (wr) begin
      check({tag, "/rdata_zero"}, HRDATA, 32'h0);
      model_write(addr, size, wdata);
    end else begin
      check({tag, "/rdata"}, HRDATA, model[addr >> 2]);
    end
    $display("xfer %s %s addr=%h size=%0d data=%h waits=%0d", tag, wr ? "WR" : "RD", addr, size,
             wr ? wdata : HRDATA, waits);
    @(posedge clk); #1;
  endtask

  task automatic err_xfer(input string tag, input bit wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata);
    HSELx = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size; ready_in = 1'b1;
    @(posedge clk); #1;
    HSELx = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    @(negedge clk);
    check({tag, "/err1_ready"}, 32'(HREADY), 32'd0);
    check({tag, "/err1_resp"}, 32'(HRESP), 32'd1);
    @(negedge clk);
    check({tag, "/err2_ready"}, 32'(HREADY), 32'd1);
    check({tag, "/err2_resp"}, 32'(HRESP), 32'd1);
    check({tag, "/err2_rdata"}, HRDATA, 32'h0);
    @(negedge clk);
    check({tag, "/idle_ready"}, 32'(HREADY), 32'd1);
    check({tag, "/idle_resp"}, 32'(HRESP), 32'd0);
    $display("xfer %s %s addr=%h size=%0d ERROR response", tag, wr ? "WR" : "RD", addr, size);
    @(posedge clk); #1;
  endtask

  initial begin
    int          waits;
    logic [31:0] rd;
    logic [31:0] a;
    logic [2:0]  sz;
    bit          wr;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst/ready", 32'(HREADY), 32'd1);
      check("rst/resp", 32'(HRESP), 32'd0);
      check("rst/rdata", HRDATA, 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst/ready", 32'(HREADY), 32'd1);
    check("post_rst/resp", 32'(HRESP), 32'd0);
    @(posedge clk); #1;

    // Known contents for the first 32 words
    for (int w = 0; w < 32; w++) okay_xfer("init", 1'b1, 32'(w) << 2, 3'd2, $urandom, rd);

    // Back-to-back write then read of the same word
    HSELx = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h10; HSIZE = 3'd2; ready_in = 1'b1;
    @(posedge clk); #1;
    HWDATA = 32'hDEADBEEF; HWRITE = 1'b0;
    wait_ready(waits);
    check("t2w/waits", 32'(waits), 32'(EXP_WAITS));
    check("t2w/resp", 32'(HRESP), 32'd0);
    $display("xfer t2w WR addr=00000010 size=2 data=deadbeef waits=%0d", waits);
    @(posedge clk); #1;
    HSELx = 1'b0; HTRANS = 2'b00;
    wait_ready(waits);
    check("t2r/waits", 32'(waits), 32'(EXP_WAITS));
    check("t2r/resp", 32'(HRESP), 32'd0);
    check("t2r/rdata", HRDATA, 32'hDEADBEEF);
    $display("xfer t2r RD addr=00000010 size=2 data=%h waits=%0d", HRDATA, waits);
    model_write(32'h10, 3'd2, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Byte and halfword lane writes
    okay_xfer("t3w", 1'b1, 32'h10, 3'd2, 32'h11223344, rd);
    okay_xfer("t3b", 1'b1, 32'h13, 3'd0, 32'hA5000000, rd);
    okay_xfer("t3r1", 1'b0, 32'h10, 3'd2, 32'h0, rd);
    check("t3r1/const", rd, 32'hA5223344);
    okay_xfer("t3h", 1'b1, 32'h12, 3'd1, 32'h5A5A0000, rd);
    okay_xfer("t3r2", 1'b0, 32'h10, 3'd2, 32'h0, rd);
    check("t3r2/const", rd, 32'h5A5A3344);

    // Error responses leave memory untouched
    err_xfer("t4oob", 1'b0, 32'h400, 3'd2, 32'h0);
    err_xfer("t4half", 1'b1, 32'h11, 3'd1, 32'hFFFFFFFF);
    err_xfer("t4size", 1'b1, 32'h10, 3'd3, 32'hFFFFFFFF);
    err_xfer("t4word", 1'b1, 32'h12, 3'd2, 32'hFFFFFFFF);
    okay_xfer("t4r", 1'b0, 32'h10, 3'd2, 32'h0, rd);
    check("t4r/const", rd, 32'h5A5A3344);

    // Transfers that must not be accepted: BUSY, IDLE, deselected, ready_in low
    for (int k = 0; k < 4; k++) begin
      HSELx    = (k != 2);
      HTRANS   = (k == 0) ? 2'b01 : (k == 1) ? 2'b00 : 2'b10;
      ready_in = (k != 3);
      HADDR = 32'h10; HWRITE = 1'b1; HSIZE = 3'd2; HWDATA = 32'hFFFF0000;
      @(posedge clk); #1;
      HSELx = 1'b0; HTRANS = 2'b00; ready_in = 1'b1; HWDATA = 32'h0BAD0BAD;
      @(negedge clk);
      check("t5/ready", 32'(HREADY), 32'd1);
      check("t5/resp", 32'(HRESP), 32'd0);
      $display("xfer t5 case=%0d ignored", k);
      @(posedge clk); #1;
    end
    okay_xfer("t5r", 1'b0, 32'h10, 3'd2, 32'h0, rd);

    // Reset during an in-flight write to 0x20
    HSELx = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h20; HSIZE = 3'd2;
    @(posedge clk); #1;
    HSELx = 1'b0; HTRANS = 2'b00; HWDATA = 32'hCAFEF00D; reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("t6/ready", 32'(HREADY), 32'd1);
    check("t6/resp", 32'(HRESP), 32'd0);
    $display("xfer t6 WR addr=00000020 abandoned by reset");
    @(posedge clk); #1;
    okay_xfer("t6r", 1'b0, 32'h20, 3'd2, 32'h0, rd);

    // Randomized mix of legal and out-of-window transfers
    for (int n = 0; n < 40; n++) begin
      sz = 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 31)) << 2;
      if (sz == 3'd0) a = a + 32'($urandom_range(0, 3));
      else if (sz == 3'd1) a = a + (32'($urandom_range(0, 1)) << 1);
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) err_xfer("rnd_err", wr, 32'h400 + a, sz, $urandom);
      else okay_xfer("rnd", wr, a, sz, $urandom, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
